// File: rtl/segway_math_pipe.sv
// segway_math_pipe: turns PID output plus steering pot into slew-limited signed left/right motor speeds.
// Latency: 3 clk from an accepted vld to spd_vld; a new sample may be accepted every clk.
// Backpressure: none. vld is a strobe and is ignored while pwr_up is low or rst_n is low.
// Ports: clk, rst_n (synchronous, active-low); vld/PID_cntrl/steer_pot/en_steer/pwr_up inputs;
//        lft_spd/rght_spd signed speeds held between samples, spd_vld strobe, too_fast overspeed flag.
module segway_math_pipe #(
    parameter int          PID_W           = 12,
    parameter int          SPD_W           = 12,
    parameter logic [12:0] MIN_DUTY        = 13'h3C0,
    parameter logic [7:0]  LOW_TORQUE_BAND = 8'h3C,
    parameter logic [5:0]  GAIN_MULT       = 6'h10,
    parameter logic [11:0] SLEW_MAX        = 12'h040,
    parameter logic [11:0] FAST_THRESH     = 12'd1792,
    parameter int          FAST_CNT        = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vld,
    input  logic [PID_W-1:0] PID_cntrl,
    input  logic [11:0]      steer_pot,
    input  logic             en_steer,
    input  logic             pwr_up,
    output logic [SPD_W-1:0] lft_spd,
    output logic [SPD_W-1:0] rght_spd,
    output logic             spd_vld,
    output logic             too_fast
);
    localparam int TQ_W     = PID_W + 1;       // torque width
    localparam int PR_W     = PID_W + 9;       // PID times 9-bit non-negative ss_tmr
    localparam int EW       = TQ_W + 8;        // headroom for shaping before saturation
    localparam int DW       = SPD_W + 1;       // speed difference width
    localparam int CW       = $clog2(FAST_CNT + 1);
    localparam int SAT_HI_I = (1 << (SPD_W - 1)) - 1;
    localparam int SAT_LO_I = -(1 << (SPD_W - 1));

    localparam logic signed [EW-1:0]    BAND_X     = EW'(LOW_TORQUE_BAND);
    localparam logic signed [EW-1:0]    MIN_DUTY_X = EW'(MIN_DUTY);
    localparam logic signed [EW-1:0]    GAIN_X     = EW'(GAIN_MULT);
    localparam logic signed [EW-1:0]    SAT_HI     = EW'(SAT_HI_I);
    localparam logic signed [EW-1:0]    SAT_LO     = EW'(SAT_LO_I);
    localparam logic signed [DW-1:0]    SLEW_P     = DW'(SLEW_MAX);
    localparam logic signed [DW-1:0]    SLEW_N     = -SLEW_P;
    localparam logic signed [SPD_W-1:0] FAST_X     = SPD_W'(FAST_THRESH);
    localparam logic [CW-1:0]           CNT_MAX    = CW'(FAST_CNT);

    // ---------------- state ----------------
    logic [7:0]              ss_tmr;
    logic                    s1_vld;
    logic signed [PID_W-1:0] s1_pid_ss;
    logic signed [TQ_W-1:0]  s1_steer;
    logic                    s1_en;
    logic                    s2_vld;
    logic [SPD_W-1:0]        s2_tgt_l;
    logic [SPD_W-1:0]        s2_tgt_r;
    logic [CW-1:0]           fast_cnt;

    // ---------------- stage 1: soft-start scaling and steering term ----------------
    logic signed [PR_W-1:0]  prod;
    logic signed [PID_W-1:0] pid_ss_c;
    logic [11:0]             steer_lmt;
    logic [11:0]             s12;
    logic signed [TQ_W-1:0]  s_x;
    logic signed [TQ_W-1:0]  steer_c;

    assign prod     = $signed({{9{PID_cntrl[PID_W-1]}}, PID_cntrl}) *
                      $signed({{(PID_W + 1){1'b0}}, ss_tmr});
    assign pid_ss_c = PID_W'(prod >>> 8);

    always_comb begin
        steer_lmt = steer_pot;
        if (steer_pot[11:8] >= 4'hE) begin
            steer_lmt = 12'hE00;
        end else if (steer_pot[11:8] <= 4'h2) begin
            steer_lmt = 12'h200;
        end
    end

    // Clamped pot minus mid-scale always fits in 12 signed bits.
    assign s12     = steer_lmt - 12'h7FF;
    assign s_x     = $signed({{(TQ_W - 12){s12[11]}}, s12});
    // Roughly 3/16 of the pot offset, built from two arithmetic shifts.
    assign steer_c = (s_x >>> 2) - (s_x >>> 4);

    // ---------------- stage 2: torque mix, shaping, saturation ----------------
    function automatic logic [SPD_W-1:0] shape_sat(input logic signed [TQ_W-1:0] t);
        logic signed [EW-1:0] tx;
        logic signed [EW-1:0] mag;
        logic signed [EW-1:0] v;
        tx  = EW'(t);
        mag = tx[EW-1] ? -tx : tx;
        // Above the low band add deadband compensation away from zero;
        // inside it, boost the small torque linearly.
        if (mag > BAND_X) begin
            v = tx[EW-1] ? (tx - MIN_DUTY_X) : (tx + MIN_DUTY_X);
        end else begin
            v = tx * GAIN_X;
        end
        if (v > SAT_HI) begin
            v = SAT_HI;
        end else if (v < SAT_LO) begin
            v = SAT_LO;
        end
        return SPD_W'(v);
    endfunction

    logic signed [TQ_W-1:0] pid_t;
    logic signed [TQ_W-1:0] tq_l;
    logic signed [TQ_W-1:0] tq_r;

    assign pid_t = $signed({s1_pid_ss[PID_W-1], s1_pid_ss});
    assign tq_l  = s1_en ? (pid_t + s1_steer) : pid_t;
    assign tq_r  = s1_en ? (pid_t - s1_steer) : pid_t;

    // ---------------- stage 3: slew limit and overspeed debounce ----------------
    function automatic logic [SPD_W-1:0] slew_step(input logic [SPD_W-1:0] tgt,
                                                   input logic [SPD_W-1:0] cur);
        logic signed [DW-1:0] d;
        logic signed [DW-1:0] step;
        d = $signed({tgt[SPD_W-1], tgt}) - $signed({cur[SPD_W-1], cur});
        if (d > SLEW_P) begin
            step = SLEW_P;
        end else if (d < SLEW_N) begin
            step = SLEW_N;
        end else begin
            step = d;
        end
        // The step moves toward an in-range target, so the sum cannot wrap.
        return cur + SPD_W'(step);
    endfunction

    logic [SPD_W-1:0] lft_nxt;
    logic [SPD_W-1:0] rght_nxt;
    logic             fast;
    logic [CW-1:0]    cnt_nxt;

    assign lft_nxt  = slew_step(s2_tgt_l, lft_spd);
    assign rght_nxt = slew_step(s2_tgt_r, rght_spd);
    assign fast     = ($signed(s2_tgt_l) > FAST_X) || ($signed(s2_tgt_r) > FAST_X);

    always_comb begin
        cnt_nxt = '0;
        if (fast) begin
            cnt_nxt = (fast_cnt == CNT_MAX) ? fast_cnt : fast_cnt + 1'b1;
        end
    end

    // ---------------- control / output registers ----------------
    // Dropping pwr_up behaves like reset: the ramp restarts and in-flight samples vanish.
    always_ff @(posedge clk) begin
        if (!rst_n || !pwr_up) begin
            ss_tmr   <= '0;
            s1_vld   <= 1'b0;
            s2_vld   <= 1'b0;
            spd_vld  <= 1'b0;
            lft_spd  <= '0;
            rght_spd <= '0;
            fast_cnt <= '0;
            too_fast <= 1'b0;
        end else begin
            s1_vld  <= vld;
            s2_vld  <= s1_vld;
            spd_vld <= s2_vld;
            if (vld && (ss_tmr != 8'hFF)) begin
                ss_tmr <= ss_tmr + 8'd1;
            end
            if (s2_vld) begin
                lft_spd  <= lft_nxt;
                rght_spd <= rght_nxt;
                fast_cnt <= cnt_nxt;
                too_fast <= (cnt_nxt == CNT_MAX);
            end
        end
    end

    // ---------------- datapath registers (qualified by the valids above) ----------------
    always_ff @(posedge clk) begin
        if (vld) begin
            s1_pid_ss <= pid_ss_c;
            s1_steer  <= steer_c;
            s1_en     <= en_steer;
        end
        if (s1_vld) begin
            s2_tgt_l <= shape_sat(tq_l);
            s2_tgt_r <= shape_sat(tq_r);
        end
    end

endmodule

// File: tb/tb_segway_math_pipe.sv
module tb_segway_math_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vld;
    logic [11:0] PID_cntrl;
    logic [11:0] steer_pot;
    logic        en_steer;
    logic        pwr_up;
    logic [11:0] lft_spd;
    logic [11:0] rght_spd;
    logic        spd_vld;
    logic        too_fast;

    int errors = 0;
    int checks = 0;
    int edge_cnt = 0;

    segway_math_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vld       (vld),
        .PID_cntrl (PID_cntrl),
        .steer_pot (steer_pot),
        .en_steer  (en_steer),
        .pwr_up    (pwr_up),
        .lft_spd   (lft_spd),
        .rght_spd  (rght_spd),
        .spd_vld   (spd_vld),
        .too_fast  (too_fast)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // ---------------- reference model ----------------
    typedef struct {
        int due;
        int l;
        int r;
        bit tf;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   m_ss  = 0;
    int   m_l   = 0;
    int   m_r   = 0;
    int   m_cnt = 0;

    function automatic logic [11:0] u12(input int x);
        logic [11:0] v;
        v = 12'(x);
        return v;
    endfunction

    function automatic int steer_term_of(input int pot);
        int lmt;
        int s;
        if ((pot / 256) >= 14) lmt = 'hE00;
        else if ((pot / 256) <= 2) lmt = 'h200;
        else lmt = pot;
        s = lmt - 'h7FF;
        return (s >>> 2) - (s >>> 4);
    endfunction

    function automatic int shape(input int t);
        int v;
        if (t > 60 || t < -60) v = (t >= 0) ? t + 960 : t - 960;
        else v = t * 16;
        if (v > 2047) v = 2047;
        if (v < -2048) v = -2048;
        return v;
    endfunction

    function automatic int clamp64(input int d);
        if (d > 64) return 64;
        if (d < -64) return -64;
        return d;
    endfunction

    task automatic model_push(input logic [11:0] pid, input logic [11:0] pot, input logic en);
        int   pss;
        int   st;
        int   gl;
        int   gr;
        exp_t e;
        pss = (int'($signed(pid)) * m_ss) >>> 8;
        st  = en ? steer_term_of(int'(pot)) : 0;
        gl  = shape(pss + st);
        gr  = shape(pss - st);
        m_l = m_l + clamp64(gl - m_l);
        m_r = m_r + clamp64(gr - m_r);
        if (gl > 1792 || gr > 1792) m_cnt = (m_cnt < 4) ? m_cnt + 1 : 4;
        else m_cnt = 0;
        e.due = edge_cnt + 3;
        e.l   = m_l;
        e.r   = m_r;
        e.tf  = (m_cnt == 4);
        exp_q.push_back(e);
        if (m_ss < 255) m_ss++;
    endtask

    // Discard samples that would complete on or after the clearing edge.
    task automatic model_clear();
        while (exp_q.size() > 0 && exp_q[$].due > edge_cnt) void'(exp_q.pop_back());
        m_ss  = 0;
        m_l   = 0;
        m_r   = 0;
        m_cnt = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    // ---------------- output monitor ----------------
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].due == edge_cnt) begin
            mon_e = exp_q.pop_front();
            check("spd_vld_pulse", 32'(spd_vld), 32'(1'b1));
            check("lft_spd", 32'(lft_spd), 32'(u12(mon_e.l)));
            check("rght_spd", 32'(rght_spd), 32'(u12(mon_e.r)));
            check("too_fast", 32'(too_fast), 32'(mon_e.tf));
        end else if (rst_n === 1'b1 || edge_cnt > 0) begin
            check("spd_vld_idle", 32'(spd_vld), 32'(1'b0));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [11:0] pid, input logic [11:0] pot, input logic en);
        vld       = 1'b1;
        PID_cntrl = pid;
        steer_pot = pot;
        en_steer  = en;
        if (pwr_up && rst_n) model_push(pid, pot, en);
        tick();
        vld = 1'b0;
    endtask

    task automatic idle(input int n);
        vld = 1'b0;
        repeat (n) tick();
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_lft"}, 32'(lft_spd), 32'(12'h000));
        check({tag, "_rght"}, 32'(rght_spd), 32'(12'h000));
        check({tag, "_vld"}, 32'(spd_vld), 32'(1'b0));
        check({tag, "_fast"}, 32'(too_fast), 32'(1'b0));
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        model_clear();
        tick();
        check_cleared("reset_pulse");
        rst_n = 1'b1;
    endtask

    task automatic drop_power(input int n);
        pwr_up = 1'b0;
        model_clear();
        tick();
        check_cleared("pwr_drop");
        send(12'h100, 12'h800, 1'b0);   // must be ignored
        idle(n);
        check_cleared("pwr_low_hold");
        pwr_up = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        rst_n     = 1'b0;
        pwr_up    = 1'b0;
        vld       = 1'b0;
        PID_cntrl = '0;
        steer_pot = 12'h800;
        en_steer  = 1'b0;
        repeat (3) tick();
        check_cleared("reset");
        rst_n  = 1'b1;
        pwr_up = 1'b1;
        tick();

        // First sample uses ss_tmr=0: zero output, spd_vld three clocks later.
        send(12'h100, 12'h800, 1'b0);
        idle(2);
        check("first_vld_at_3", 32'(spd_vld), 32'(1'b1));
        check("first_lft", 32'(lft_spd), 32'(12'h000));
        check("first_rght", 32'(rght_spd), 32'(12'h000));
        check("first_fast", 32'(too_fast), 32'(1'b0));

        // Saturate the ramp, then settle on 0x4BF.
        repeat (254) send(12'h100, 12'h800, 1'b0);
        repeat (25) send(12'h100, 12'h800, 1'b0);
        idle(4);
        check("settle_4bf_l", 32'(lft_spd), 32'(12'h4BF));
        check("settle_4bf_r", 32'(rght_spd), 32'(12'h4BF));

        // Low band gain path, then large negative torque.
        repeat (25) send(12'h020, 12'h800, 1'b0);
        idle(4);
        check("low_band_l", 32'(lft_spd), 32'(12'h1F0));
        repeat (40) send(12'hF00, 12'h800, 1'b0);
        idle(4);
        check("neg_l", 32'(lft_spd), 32'(12'hB41));
        check("neg_r", 32'(rght_spd), 32'(12'hB41));

        // Steering at the upper clamp, then steering disabled.
        repeat (45) send(12'h000, 12'hFFF, 1'b1);
        idle(4);
        check("steer_l", 32'(lft_spd), 32'(12'h4E0));
        check("steer_r", 32'(rght_spd), 32'(12'hB20));
        repeat (45) send(12'h000, 12'hFFF, 1'b0);
        idle(4);
        check("steer_off_l", 32'(lft_spd), 32'(12'h000));
        check("steer_off_r", 32'(rght_spd), 32'(12'h000));

        // Overspeed debounce.
        repeat (3) send(12'h7FF, 12'h800, 1'b0);
        idle(4);
        check("fast_after_3", 32'(too_fast), 32'(1'b0));
        send(12'h7FF, 12'h800, 1'b0);
        idle(4);
        check("fast_after_4", 32'(too_fast), 32'(1'b1));
        send(12'h000, 12'h800, 1'b0);
        idle(4);
        check("fast_cleared", 32'(too_fast), 32'(1'b0));
        repeat (35) send(12'h7FF, 12'h800, 1'b0);
        idle(4);
        check("sat_l", 32'(lft_spd), 32'(12'h7FF));
        check("sat_fast", 32'(too_fast), 32'(1'b1));

        // Power drop with samples in flight; the ramp restarts.
        send(12'h7FF, 12'h800, 1'b0);
        send(12'h7FF, 12'h800, 1'b0);
        drop_power(3);

        // Randomized traffic with a reset and a power drop in the middle.
        for (int i = 0; i < 400; i++) begin
            if (i == 150) pulse_reset();
            if (i == 260) drop_power(2);
            if ($urandom_range(1, 0) == 1)
                send(12'($urandom), 12'($urandom_range(4095, 0)), 1'($urandom_range(1, 0)));
            else
                idle(1);
        end

        // Reset with samples in flight; second post-reset sample uses ss_tmr=1.
        send(12'h7FF, 12'h800, 1'b0);
        send(12'h7FF, 12'h800, 1'b0);
        pulse_reset();
        send(12'h7FF, 12'h800, 1'b0);
        send(12'h7FF, 12'h800, 1'b0);
        idle(2);
        check("restart_vld", 32'(spd_vld), 32'(1'b1));
        check("restart_step", 32'(lft_spd), 32'(12'h040));

        idle(6);
        check("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
